// File: rtl/window_counter_scheduler.sv
// Shares one window_counter across N_CHANNELS pulse sources, one full window per channel.
// Optional per-channel stall flags are built only when STALL_DETECT_EN is defined.
module window_counter_scheduler #(
  parameter int N_CHANNELS    = 3,
  parameter int COUNTER_WIDTH = 12,
  parameter int CLEAR_CYCLES  = 2,
  parameter int SETTLE_LIMIT  = 255,
  parameter int STALL_THRESH  = 4,
  localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     continuous,
  input  logic [N_CHANNELS-1:0]    ch_pulse,
  output logic                     wc_enable,
  output logic                     wc_reset_n,
  input  logic [COUNTER_WIDTH-1:0] wc_counter,
  input  logic                     wc_valid,
  input  logic                     wc_updated,
  output logic [CH_W-1:0]          channel_sel,
  output logic                     busy,
  output logic                     result_strobe,
  output logic [CH_W-1:0]          result_ch,
  output logic [COUNTER_WIDTH-1:0] result_value,
  output logic                     result_err,
  output logic                     timeout_err,
  output logic                     sweep_done,
  output logic [N_CHANNELS-1:0]    stall
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam int UPD_W = (SETTLE_LIMIT > 1) ? $clog2(SETTLE_LIMIT) : 1;
  localparam logic [CLR_W-1:0] CLEAR_LAST  = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [UPD_W-1:0] SETTLE_LAST = UPD_W'(SETTLE_LIMIT - 1);
  localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(N_CHANNELS - 1);

  if (N_CHANNELS < 2) begin : g_bad_channels
    $error("window_counter_scheduler: N_CHANNELS must be at least 2");
  end
  if (CLEAR_CYCLES < 1) begin : g_bad_clear
    $error("window_counter_scheduler: CLEAR_CYCLES must be at least 1");
  end
  if (SETTLE_LIMIT < 1) begin : g_bad_settle
    $error("window_counter_scheduler: SETTLE_LIMIT must be at least 1");
  end
  if (STALL_THRESH < 0) begin : g_bad_thresh
    $error("window_counter_scheduler: STALL_THRESH must not be negative");
  end

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FILL,
    ADVANCE
  } state_t;

  state_t             state;
  logic [CLR_W-1:0]   clear_cnt;
  logic [UPD_W-1:0]   upd_cnt;

  assign busy       = (state != IDLE);
  assign wc_reset_n = (state == FILL);
  assign wc_enable  = (state == FILL) && ch_pulse[channel_sel];

  // stop outranks everything, including a capture arriving on the same edge
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      clear_cnt     <= '0;
      upd_cnt       <= '0;
      channel_sel   <= '0;
      result_strobe <= 1'b0;
      result_ch     <= '0;
      result_value  <= '0;
      result_err    <= 1'b0;
      timeout_err   <= 1'b0;
      sweep_done    <= 1'b0;
    end else begin
      result_strobe <= 1'b0;
      sweep_done    <= 1'b0;
      if (state != IDLE && stop) begin
        state       <= IDLE;
        channel_sel <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              state       <= CLEAR;
              clear_cnt   <= '0;
              channel_sel <= '0;
              timeout_err <= 1'b0;
            end
          end
          CLEAR: begin
            upd_cnt <= '0;
            if (clear_cnt == CLEAR_LAST) begin
              state <= FILL;
            end else begin
              clear_cnt <= clear_cnt + 1'b1;
            end
          end
          FILL: begin
            // a valid window wins even when it lands on the settle limit
            if (wc_updated) begin
              if (wc_valid) begin
                result_value  <= wc_counter;
                result_ch     <= channel_sel;
                result_err    <= 1'b0;
                result_strobe <= 1'b1;
                state         <= ADVANCE;
              end else if (upd_cnt == SETTLE_LAST) begin
                result_value  <= '0;
                result_ch     <= channel_sel;
                result_err    <= 1'b1;
                result_strobe <= 1'b1;
                timeout_err   <= 1'b1;
                state         <= ADVANCE;
              end else begin
                upd_cnt <= upd_cnt + 1'b1;
              end
            end
          end
          ADVANCE: begin
            clear_cnt <= '0;
            if (channel_sel == LAST_CH) begin
              channel_sel <= '0;
              if (!continuous) begin
                state      <= IDLE;
                sweep_done <= 1'b1;
              end else begin
                state <= CLEAR;
              end
            end else begin
              channel_sel <= channel_sel + 1'b1;
              state       <= CLEAR;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef STALL_DETECT_EN
  localparam logic [COUNTER_WIDTH-1:0] STALL_LIMIT = COUNTER_WIDTH'(STALL_THRESH);

  // flags follow the strobe by one cycle; a new sweep wipes them
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      stall <= '0;
    end else if (state == IDLE && start && !stop) begin
      stall <= '0;
    end else if (result_strobe) begin
      stall[result_ch] <= result_err || (result_value < STALL_LIMIT);
    end
  end
`else
  assign stall = '0;
`endif

endmodule

// File: tb/tb_window_counter_scheduler.sv
// Randomised and directed bench for window_counter_scheduler against a transaction-level model.
// Includes a behavioural window_counter (10-tick samples, 4-sample window) driving the DUT.
module tb_window_counter_scheduler;

  localparam int N       = 3;
  localparam int CW      = 12;
  localparam int CHW     = 2;
  localparam int CLR     = 2;
  localparam int SETTLE  = 8;
  localparam int THRESH  = 4;
  localparam int PERIOD  = 10;
  localparam int SAMPLES = 4;

  logic          sys_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          continuous = 1'b0;
  logic [N-1:0]  ch_pulse = '0;
  logic          wc_enable;
  logic          wc_reset_n;
  logic [CW-1:0] wc_counter = '0;
  logic          wc_valid = 1'b0;
  logic          wc_updated = 1'b0;
  logic [CHW-1:0] channel_sel;
  logic          busy;
  logic          result_strobe;
  logic [CHW-1:0] result_ch;
  logic [CW-1:0] result_value;
  logic          result_err;
  logic          timeout_err;
  logic          sweep_done;
  logic [N-1:0]  stall;

  int total = 0;
  int passed = 0;
  bit checking = 1'b0;
  bit force_invalid = 1'b0;

  window_counter_scheduler #(
    .N_CHANNELS(N), .COUNTER_WIDTH(CW), .CLEAR_CYCLES(CLR),
    .SETTLE_LIMIT(SETTLE), .STALL_THRESH(THRESH)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .stop(stop),
    .continuous(continuous), .ch_pulse(ch_pulse), .wc_enable(wc_enable),
    .wc_reset_n(wc_reset_n), .wc_counter(wc_counter), .wc_valid(wc_valid),
    .wc_updated(wc_updated), .channel_sel(channel_sel), .busy(busy),
    .result_strobe(result_strobe), .result_ch(result_ch),
    .result_value(result_value), .result_err(result_err),
    .timeout_err(timeout_err), .sweep_done(sweep_done), .stall(stall)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural window_counter: samples the enable one cycle late, sums the last SAMPLES periods
  int wc_tick, wc_acc, wc_nsamp, wc_sum;
  bit wc_en_d;
  int wc_hist[SAMPLES];
  always @(posedge sys_clk) begin
    if (!reset_n || wc_reset_n !== 1'b1) begin
      wc_tick = 0; wc_acc = 0; wc_nsamp = 0; wc_en_d = 1'b0;
      foreach (wc_hist[i]) wc_hist[i] = 0;
      wc_updated <= 1'b0; wc_valid <= 1'b0; wc_counter <= '0;
    end else begin
      wc_acc += int'(wc_en_d);
      wc_en_d = (wc_enable === 1'b1);
      wc_tick++;
      if (wc_tick == PERIOD) begin
        for (int i = SAMPLES - 1; i > 0; i--) wc_hist[i] = wc_hist[i-1];
        wc_hist[0] = wc_acc;
        wc_acc = 0;
        wc_tick = 0;
        if (wc_nsamp < SAMPLES) wc_nsamp++;
        wc_sum = 0;
        foreach (wc_hist[i]) wc_sum += wc_hist[i];
        wc_counter <= CW'(wc_sum);
        wc_valid <= !force_invalid && (wc_nsamp == SAMPLES);
        wc_updated <= 1'b1;
      end else begin
        wc_updated <= 1'b0;
      end
    end
  end

  // Reference model: a sweep is a list of channel jobs, each job = clear period then a fill
  bit m_busy, m_adv, m_tout;
  int m_clear_left, m_upd, m_ch;
  bit [N-1:0] m_stall;
  bit e_strobe, e_done, e_rerr;
  int e_rch, e_rval;
  int m_log_ch[$], m_log_val[$];
  bit m_log_err[$];
  always @(posedge sys_clk) begin
    bit was_strobe;
    was_strobe = e_strobe;
    e_strobe = 1'b0;
    e_done = 1'b0;
    if (!reset_n) begin
      m_busy = 0; m_adv = 0; m_tout = 0; m_clear_left = 0; m_upd = 0; m_ch = 0;
      m_stall = '0; e_rerr = 0; e_rch = 0; e_rval = 0;
    end else begin
`ifdef STALL_DETECT_EN
      if (was_strobe) m_stall[e_rch] = e_rerr || (e_rval < THRESH);
`endif
      if (!m_busy) begin
        if (start && !stop) begin
          m_busy = 1; m_ch = 0; m_clear_left = CLR; m_tout = 0; m_stall = '0;
        end
      end else if (stop) begin
        m_busy = 0; m_adv = 0; m_ch = 0; m_clear_left = 0;
      end else if (m_adv) begin
        m_adv = 0;
        m_ch = (m_ch + 1) % N;
        if (m_ch == 0 && !continuous) begin
          m_busy = 0; e_done = 1;
        end else begin
          m_clear_left = CLR;
        end
      end else if (m_clear_left > 0) begin
        m_clear_left--;
        m_upd = 0;
      end else if (wc_updated) begin
        m_upd++;
        if (wc_valid) begin
          e_strobe = 1; e_rch = m_ch; e_rval = int'(wc_counter); e_rerr = 0; m_adv = 1;
        end else if (m_upd >= SETTLE) begin
          e_strobe = 1; e_rch = m_ch; e_rval = 0; e_rerr = 1; m_tout = 1; m_adv = 1;
        end
      end
      if (e_strobe) begin
        m_log_ch.push_back(e_rch); m_log_val.push_back(e_rval); m_log_err.push_back(e_rerr);
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  int d_ch[$], d_val[$];
  always @(negedge sys_clk) begin
    bit filling;
    if (checking) begin
      filling = m_busy && !m_adv && (m_clear_left == 0);
      checkOutput("busy", busy, m_busy);
      checkOutput("wc_reset_n", wc_reset_n, filling);
      checkOutput("wc_enable", wc_enable, filling && ch_pulse[m_ch]);
      checkOutput("channel_sel", channel_sel, m_ch);
      checkOutput("result_strobe", result_strobe, e_strobe);
      checkOutput("result_ch", result_ch, e_rch);
      checkOutput("result_value", result_value, e_rval);
      checkOutput("result_err", result_err, e_rerr);
      checkOutput("timeout_err", timeout_err, m_tout);
      checkOutput("sweep_done", sweep_done, e_done);
      checkOutput("stall", stall, m_stall);
      if (result_strobe === 1'b1) begin
        d_ch.push_back(int'(result_ch));
        d_val.push_back(int'(result_value));
      end
    end
  end

  task automatic applyStimulus(input bit s_start, input bit s_stop, input bit s_cont, input logic [N-1:0] s_pulse);
    start = s_start; stop = s_stop; continuous = s_cont; ch_pulse = s_pulse;
    @(posedge sys_clk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic waitIdle(input string name, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      stepCycles(1);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    checkOutput(name, ok, 1'b1);
  endtask

  task automatic waitStrobes(input string name, input int count, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (d_ch.size() >= count) begin ok = 1'b1; break; end
      stepCycles(1);
    end
    checkOutput(name, ok, 1'b1);
  endtask

  task automatic waitFill(input string name, input int ch, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (wc_reset_n === 1'b1 && channel_sel == CHW'(ch)) begin ok = 1'b1; break; end
      stepCycles(1);
    end
    checkOutput(name, ok, 1'b1);
  endtask

  task automatic checkSweepLog(input string tag, input int v0, input int v1, input int v2);
    int exp_val[3];
    exp_val[0] = v0; exp_val[1] = v1; exp_val[2] = v2;
    checkOutput({tag, "_dut_count"}, d_ch.size(), 3);
    checkOutput({tag, "_model_count"}, m_log_ch.size(), 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput({tag, "_dut_ch"}, (i < d_ch.size()) ? d_ch[i] : -1, i);
      checkOutput({tag, "_dut_val"}, (i < d_val.size()) ? d_val[i] : -1, exp_val[i]);
      checkOutput({tag, "_model_val"}, (i < m_log_val.size()) ? m_log_val[i] : -1, exp_val[i]);
    end
  endtask

  task automatic clearLogs();
    d_ch.delete(); d_val.delete(); m_log_ch.delete(); m_log_val.delete(); m_log_err.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n0;
    logic [N-1:0] exp_stall;
    reset_n = 1'b0;
    stepCycles(3);
    reset_n = 1'b1;
    checking = 1'b1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_wc_reset_n", wc_reset_n, 1'b0);
    checkOutput("rst_channel_sel", channel_sel, 0);
    checkOutput("rst_result_value", result_value, 0);
    checkOutput("rst_stall", stall, 0);

    $display("[TB] single sweep, ch_pulse=010");
    clearLogs();
    applyStimulus(1, 0, 0, 3'b010);
    waitIdle("t1_idle_reached", 1000);
    checkOutput("t1_sweep_done", sweep_done, 1'b1);
    checkSweepLog("t1", 0, 39, 0);
`ifdef STALL_DETECT_EN
    exp_stall = 3'b101;
`else
    exp_stall = 3'b000;
`endif
    checkOutput("t1_stall", stall, exp_stall);
    stepCycles(1);
    checkOutput("t1_sweep_done_pulse", sweep_done, 1'b0);

    $display("[TB] start and stop together in idle");
    applyStimulus(1, 1, 0, 3'b010);
    checkOutput("t2_stays_idle", busy, 1'b0);

    $display("[TB] timeout with window counter never valid");
    clearLogs();
    force_invalid = 1'b1;
    applyStimulus(1, 0, 0, 3'b111);
    waitStrobes("t3_strobe_seen", 1, 300);
    stepCycles(0);
    checkOutput("t3_result_err", result_err, 1'b1);
    checkOutput("t3_result_value", result_value, 0);
    checkOutput("t3_timeout_err", timeout_err, 1'b1);
    checkOutput("t3_model_err", (m_log_err.size() > 0) ? m_log_err[0] : 1'b0, 1'b1);
    applyStimulus(0, 1, 0, 3'b111);
    checkOutput("t3_sticky_after_stop", timeout_err, 1'b1);
    force_invalid = 1'b0;
    applyStimulus(1, 0, 0, 3'b111);
    checkOutput("t3_cleared_by_start", timeout_err, 1'b0);
    applyStimulus(0, 1, 0, 3'b111);

    $display("[TB] continuous sweep with ignored start");
    clearLogs();
    applyStimulus(1, 0, 1, 3'b110);
    stepCycles(20);
    applyStimulus(1, 0, 1, 3'b110);
    waitStrobes("t4_five_strobes", 5, 1500);
    for (int i = 0; i < 5; i++)
      checkOutput("t4_channel_order", (i < d_ch.size()) ? d_ch[i] : -1, i % 3);
    checkOutput("t4_ch1_value", (d_val.size() > 1) ? d_val[1] : -1, 39);
    applyStimulus(0, 1, 1, 3'b110);
    checkOutput("t4_stopped", busy, 1'b0);

    $display("[TB] stop during fill of ch1");
    clearLogs();
    applyStimulus(1, 0, 0, 3'b010);
    waitFill("t5_ch1_fill", 1, 300);
    stepCycles(15);
    n0 = d_ch.size();
    applyStimulus(0, 1, 0, 3'b010);
    checkOutput("t5_busy", busy, 1'b0);
    checkOutput("t5_wc_reset_n", wc_reset_n, 1'b0);
    checkOutput("t5_channel_sel", channel_sel, 0);
    stepCycles(60);
    checkOutput("t5_no_strobe", d_ch.size(), n0);

    $display("[TB] reset during fill");
    applyStimulus(1, 0, 0, 3'b010);
    waitFill("t6_ch0_fill", 0, 50);
    stepCycles(12);
    reset_n = 1'b0;
    stepCycles(1);
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_wc_reset_n", wc_reset_n, 1'b0);
    checkOutput("t6_result_err", result_err, 1'b0);
    reset_n = 1'b1;
    clearLogs();
    applyStimulus(1, 0, 0, 3'b010);
    waitIdle("t6_sweep_after_reset", 1000);
    checkSweepLog("t6", 0, 39, 0);

    $display("[TB] continuous with all channels pulsing");
    clearLogs();
    applyStimulus(1, 0, 1, 3'b111);
    waitStrobes("t7_three_strobes", 3, 1000);
    stepCycles(2);
    checkOutput("t7_stall_clear", stall, 0);
    applyStimulus(0, 1, 1, 3'b111);

    $display("[TB] randomised traffic");
    for (int c = 0; c < 4000; c++) begin
      bit r_start, r_stop;
      r_start = ($urandom_range(0, 99) < 3);
      r_stop  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 499) == 0) continuous = ~continuous;
      if ($urandom_range(0, 699) == 0) force_invalid = ~force_invalid;
      if ($urandom_range(0, 1499) == 0) reset_n = 1'b0;
      applyStimulus(r_start, r_stop, continuous, N'($urandom));
      reset_n = 1'b1;
    end
    force_invalid = 1'b0;
    applyStimulus(0, 1, 0, '0);
    stepCycles(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
